// File: rtl/fs_sequencer_pkg.sv
// Shared types and constants for the 256fs startup sequencer.
// States, default timing constants and the sequencing counter width.
package fs_sequencer_pkg;

  localparam int CNT_W                = 16;
  localparam int DEF_LOCK_FILT        = 64;
  localparam int DEF_CODEC_RST_CYCLES = 256;
  localparam int DEF_SETTLE_CYCLES    = 1024;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    CODEC_RST = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fs_sequencer_lock_sync.sv
// Two-flop synchronizer that brings the asynchronous PLL lock into the 256fs domain.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fs_sequencer.sv
// Codec/DSP startup sequencer and sample-frame phase generator on the 256fs clock.
// Define FS_SEQUENCER_LOCK_CNT_EN to add the saturating lock_lost_count output.
module fs_sequencer
  import fs_sequencer_pkg::*;
#(
  parameter int LOCK_FILT        = DEF_LOCK_FILT,
  parameter int CODEC_RST_CYCLES = DEF_CODEC_RST_CYCLES,
  parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES
) (
  input  logic       clk_256fs,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       rst_codec,
  output logic       rst_dsp,
  output logic       strobe_fs,
  output logic [7:0] fs_phase,
  output logic       running
`ifdef FS_SEQUENCER_LOCK_CNT_EN
  ,
  output logic [7:0] lock_lost_count
`endif
);

  // Terminal counts; each parameter is expected to lie in 1..65535.
  localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] CODEC_LAST  = CNT_W'(CODEC_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             lock_s;
  logic             lock_drop;
  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       phase_nxt;

  lock_sync u_lock_sync (
    .clk (clk_256fs),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign lock_drop = (state != WAIT_LOCK) && !lock_s;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = 8'd0;
    // Lock loss outranks any terminal count reached on the same cycle.
    if (lock_drop) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_nxt = '0;
          end else if (cnt == FILT_LAST) begin
            state_nxt = CODEC_RST;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        CODEC_RST: begin
          if (cnt == CODEC_LAST) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        RUN: begin
          cnt_nxt = '0;
        end
      endcase
    end
    if (state_nxt == RUN && state == RUN) begin
      phase_nxt = fs_phase + 8'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rst_codec <= 1'b1;
      rst_dsp   <= 1'b1;
      running   <= 1'b0;
      fs_phase  <= 8'd0;
      strobe_fs <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_codec <= (state_nxt == WAIT_LOCK) || (state_nxt == CODEC_RST);
      rst_dsp   <= (state_nxt != RUN);
      running   <= (state_nxt == RUN);
      fs_phase  <= phase_nxt;
      strobe_fs <= (state_nxt == RUN) && (phase_nxt == 8'hFF);
    end
  end

`ifdef FS_SEQUENCER_LOCK_CNT_EN
  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      lock_lost_count <= 8'd0;
    end else if (lock_drop && lock_lost_count != 8'hFF) begin
      lock_lost_count <= lock_lost_count + 8'd1;
    end
  end
`else
  // Lock-loss event counting is not built in this configuration.
`endif

endmodule

// File: tb/tb_fs_sequencer.sv
// Self-checking bench for fs_sequencer: a timeline model of the startup sequence
// is compared every cycle, plus hand-counted cycle positions for the key scenarios.
module tb_fs_sequencer;

  localparam int LF  = 4;
  localparam int CRC = 8;
  localparam int STC = 16;

  logic       clk_256fs = 1'b0;
  logic       rst       = 1'b1;
  logic       pll_lock  = 1'b0;
  logic       rst_codec;
  logic       rst_dsp;
  logic       strobe_fs;
  logic [7:0] fs_phase;
  logic       running;
`ifdef FS_SEQUENCER_LOCK_CNT_EN
  logic [7:0] lock_lost_count;
`endif

  int testsRun = 0;
  int failures = 0;

  fs_sequencer #(
    .LOCK_FILT        (LF),
    .CODEC_RST_CYCLES (CRC),
    .SETTLE_CYCLES    (STC)
  ) dut (
    .clk_256fs       (clk_256fs),
    .rst             (rst),
    .pll_lock        (pll_lock),
    .rst_codec       (rst_codec),
    .rst_dsp         (rst_dsp),
    .strobe_fs       (strobe_fs),
    .fs_phase        (fs_phase),
    .running         (running)
`ifdef FS_SEQUENCER_LOCK_CNT_EN
    ,
    .lock_lost_count (lock_lost_count)
`endif
  );

  always #5 clk_256fs = ~clk_256fs;

  // Model: the sequence is a timeline measured in cycles since startup began.
  bit mStarted = 1'b0;
  int mHigh    = 0;
  int mElapsed = 0;
  int mLost    = 0;
  bit mS1      = 1'b0;
  bit mS2      = 1'b0;

  always @(posedge clk_256fs) begin
    if (rst) begin
      mStarted = 1'b0;
      mHigh    = 0;
      mElapsed = 0;
      mLost    = 0;
      mS1      = 1'b0;
      mS2      = 1'b0;
    end else begin
      if (!mStarted) begin
        if (mS2) begin
          mHigh++;
          if (mHigh == LF) begin
            mStarted = 1'b1;
            mElapsed = 0;
            mHigh    = 0;
          end
        end else begin
          mHigh = 0;
        end
      end else if (!mS2) begin
        mStarted = 1'b0;
        mHigh    = 0;
        if (mLost < 255) mLost++;
      end else begin
        mElapsed++;
      end
      mS2 = mS1;
      mS1 = pll_lock;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l);
    rst      = r;
    pll_lock = l;
    @(negedge clk_256fs);
  endtask

  always @(negedge clk_256fs) begin
    bit expCodec, expDsp, expRun, expStrobe;
    int expPhase;
    expCodec  = !mStarted || (mElapsed < CRC);
    expDsp    = !mStarted || (mElapsed < CRC + STC);
    expRun    = !expDsp;
    expPhase  = expRun ? ((mElapsed - CRC - STC) % 256) : 0;
    expStrobe = expRun && (expPhase == 255);
    checkOutput("rst_codec", 32'(rst_codec), 32'(expCodec));
    checkOutput("rst_dsp",   32'(rst_dsp),   32'(expDsp));
    checkOutput("running",   32'(running),   32'(expRun));
    checkOutput("fs_phase",  32'(fs_phase),  32'(expPhase));
    checkOutput("strobe_fs", 32'(strobe_fs), 32'(expStrobe));
`ifdef FS_SEQUENCER_LOCK_CNT_EN
    checkOutput("lock_lost_count", 32'(lock_lost_count), 32'(mLost));
`endif
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    int n;
    bit sawRun;

    // Reset for 3 cycles, then lock held high through startup.
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("reset_rst_codec", 32'(rst_codec), 32'd1);
    checkOutput("reset_rst_dsp",   32'(rst_dsp),   32'd1);
    checkOutput("reset_running",   32'(running),   32'd0);
    checkOutput("reset_fs_phase",  32'(fs_phase),  32'd0);
    checkOutput("reset_strobe",    32'(strobe_fs), 32'd0);
    applyStimulus(1'b0, 1'b1);
    n = 1;
    while (rst_codec !== 1'b0 && n < 100) begin @(negedge clk_256fs); n++; end
    checkOutput("s1_codec_release_cycle", 32'(n), 32'd14);
    while (running !== 1'b1 && n < 200) begin @(negedge clk_256fs); n++; end
    checkOutput("s1_run_entry_cycle", 32'(n), 32'd30);
    checkOutput("s1_rst_dsp_low", 32'(rst_dsp), 32'd0);
    while (strobe_fs !== 1'b1 && n < 600) begin @(negedge clk_256fs); n++; end
    checkOutput("s1_first_strobe_cycle", 32'(n), 32'd285);
    checkOutput("s1_strobe_phase", 32'(fs_phase), 32'd255);

    // Reset while running.
    repeat (40) @(negedge clk_256fs);
    applyStimulus(1'b1, 1'b1);
    checkOutput("s6_rst_codec", 32'(rst_codec), 32'd1);
    checkOutput("s6_rst_dsp",   32'(rst_dsp),   32'd1);
    checkOutput("s6_running",   32'(running),   32'd0);
    checkOutput("s6_fs_phase",  32'(fs_phase),  32'd0);
`ifdef FS_SEQUENCER_LOCK_CNT_EN
    checkOutput("s6_lock_lost_count", 32'(lock_lost_count), 32'd0);
`endif

    // One-cycle lock drop while running at fs_phase 100.
    rst = 1'b0;
    n = 0;
    while (fs_phase !== 8'd100 && n < 400) begin @(negedge clk_256fs); n++; end
    checkOutput("s3_reached_phase100", 32'(fs_phase), 32'd100);
    applyStimulus(1'b0, 1'b0);
    pll_lock = 1'b1;
    n = 1;
    while (rst_dsp !== 1'b1 && n < 20) begin @(negedge clk_256fs); n++; end
    checkOutput("s3_reassert_latency", 32'(n), 32'd3);
    checkOutput("s3_codec_reasserted", 32'(rst_codec), 32'd1);
    checkOutput("s3_phase_cleared", 32'(fs_phase), 32'd0);
    checkOutput("s3_running_low", 32'(running), 32'd0);
`ifdef FS_SEQUENCER_LOCK_CNT_EN
    checkOutput("s3_lock_lost_count", 32'(lock_lost_count), 32'd1);
`endif
    n = 0;
    while (running !== 1'b1 && n < 100) begin @(negedge clk_256fs); n++; end
    checkOutput("s3_rerun", 32'(running), 32'd1);

    // Lock glitch pattern restarts the filter.
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, pat[i] != 0);
    n = 8;
    while (rst_codec !== 1'b0 && n < 100) begin @(negedge clk_256fs); n++; end
    checkOutput("s2_codec_release_cycle", 32'(n), 32'd18);

    // Lock loss landing on the final SETTLE cycle.
    n = 0;
    while (!(mStarted && mElapsed == CRC + STC - 3) && n < 100) begin @(negedge clk_256fs); n++; end
    checkOutput("s4_reached_settle_end", 32'(mElapsed), 32'(CRC + STC - 3));
    applyStimulus(1'b0, 1'b0);
    pll_lock = 1'b1;
    sawRun = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_256fs);
      if (running === 1'b1) sawRun = 1'b1;
    end
    checkOutput("s4_running_never_rose", 32'(sawRun), 32'd0);

    // Repeated forced lock losses.
    for (int k = 0; k < 300; k++) begin
      repeat (8) applyStimulus(1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0);
    end
`ifdef FS_SEQUENCER_LOCK_CNT_EN
    checkOutput("s5_lock_lost_saturated", 32'(lock_lost_count), 32'd255);
`endif

    // Random lock stretches, drops and occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      int hi, lo;
      if ($urandom_range(0, 9) == 0) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      hi = $urandom_range(0, 350);
      lo = $urandom_range(1, 3);
      for (int c = 0; c < hi; c++) applyStimulus(1'b0, 1'b1);
      for (int c = 0; c < lo; c++) applyStimulus(1'b0, 1'b0);
    end
    repeat (5) applyStimulus(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
